// File: rtl/ysyx_25030093_mc_ctrl.sv
// Multi-cycle core controller: sequences fetch, execute, memory access and writeback.
// Optional bus watchdog enabled by defining YSYX_25030093_BUS_TIMEOUT_EN.
module ysyx_25030093_mc_ctrl #(
   parameter int unsigned       XLEN     = 32,
   parameter logic [XLEN-1:0]   RESET_PC = XLEN'(32'h8000_0000),
   parameter int unsigned       CNT_W    = 64,
   parameter int unsigned       TIMEOUT  = 255
) (
   input  logic             clk,
   input  logic             rst,
   output logic             ifu_req_valid,
   input  logic             ifu_req_ready,
   output logic [XLEN-1:0]  ifu_req_addr,
   input  logic             ifu_rsp_valid,
   input  logic [31:0]      ifu_rsp_inst,
   input  logic             is_mem,
   input  logic             ebreak,
   output logic             lsu_req_valid,
   input  logic             lsu_req_ready,
   input  logic             lsu_rsp_valid,
   input  logic [XLEN-1:0]  next_pc,
   output logic [XLEN-1:0]  pc,
   output logic [31:0]      inst,
   output logic             commit,
   output logic [CNT_W-1:0] retired,
   output logic             halted,
   output logic             bus_err
);

   typedef enum logic [2:0] {
      S_FETCH_REQ,
      S_FETCH_WAIT,
      S_EXEC,
      S_MEM_REQ,
      S_MEM_WAIT,
      S_WB,
      S_HALT
   } state_e;

   state_e           state_q, state_d;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic [31:0]      inst_q, inst_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             ifu_req_valid_q;
   logic             lsu_req_valid_q;
   logic             halted_q;

`ifdef YSYX_25030093_BUS_TIMEOUT_EN
   localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);
   logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              bus_err_q, bus_err_d;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
`endif

   // Commit is decoded from the current state so the ebreak pulse lands in EXEC itself.
   assign commit = (state_q == S_WB) || ((state_q == S_EXEC) && ebreak);

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      retired_d = retired_q;

      case (state_q)
         S_FETCH_REQ:  if (ifu_req_valid_q && ifu_req_ready) state_d = S_FETCH_WAIT;
         S_FETCH_WAIT: begin
            if (ifu_rsp_valid) begin
               inst_d  = ifu_rsp_inst;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (ebreak)      state_d = S_HALT;
            else if (is_mem) state_d = S_MEM_REQ;
            else             state_d = S_WB;
         end
         S_MEM_REQ:    if (lsu_req_valid_q && lsu_req_ready) state_d = S_MEM_WAIT;
         S_MEM_WAIT:   if (lsu_rsp_valid) state_d = S_WB;
         S_WB: begin
            pc_d    = next_pc;
            state_d = S_FETCH_REQ;
         end
         S_HALT:       state_d = S_HALT;
         default:      state_d = S_FETCH_REQ;
      endcase

      if (commit) retired_d = retired_q + CNT_W'(1);

`ifdef YSYX_25030093_BUS_TIMEOUT_EN
      wait_cnt_d = '0;
      bus_err_d  = bus_err_q;
      if ((state_q inside {S_FETCH_REQ, S_FETCH_WAIT, S_MEM_REQ, S_MEM_WAIT}) &&
          (state_d == state_q)) begin
         wait_cnt_d = wait_cnt_q + WCNT_W'(1);
         if (wait_cnt_d >= WCNT_W'(TIMEOUT)) begin
            state_d   = S_HALT;
            bus_err_d = 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= S_FETCH_REQ;
         pc_q            <= RESET_PC;
         inst_q          <= '0;
         retired_q       <= '0;
         ifu_req_valid_q <= 1'b0;
         lsu_req_valid_q <= 1'b0;
         halted_q        <= 1'b0;
`ifdef YSYX_25030093_BUS_TIMEOUT_EN
         wait_cnt_q      <= '0;
         bus_err_q       <= 1'b0;
`endif
      end else begin
         state_q         <= state_d;
         pc_q            <= pc_d;
         inst_q          <= inst_d;
         retired_q       <= retired_d;
         // Handshake outputs track the state being entered, so they rise with it.
         ifu_req_valid_q <= (state_d == S_FETCH_REQ);
         lsu_req_valid_q <= (state_d == S_MEM_REQ);
         halted_q        <= (state_d == S_HALT);
`ifdef YSYX_25030093_BUS_TIMEOUT_EN
         wait_cnt_q      <= wait_cnt_d;
         bus_err_q       <= bus_err_d;
`endif
      end
   end

   assign ifu_req_valid = ifu_req_valid_q;
   assign ifu_req_addr  = pc_q;
   assign lsu_req_valid = lsu_req_valid_q;
   assign pc            = pc_q;
   assign inst          = inst_q;
   assign retired       = retired_q;
   assign halted        = halted_q;
`ifdef YSYX_25030093_BUS_TIMEOUT_EN
   assign bus_err       = bus_err_q;
`else
   assign bus_err       = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_25030093_mc_ctrl.sv
// Self-checking bench for ysyx_25030093_mc_ctrl: table vectors, corner sequences, random instructions.
module tb_ysyx_25030093_mc_ctrl;
   localparam int unsigned     CW  = 4;
   localparam logic [31:0]     RPC = 32'h8000_0000;

   logic          clk = 1'b0;
   logic          rst;
   logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
   logic [31:0]   ifu_req_addr, ifu_rsp_inst;
   logic          is_mem, ebreak;
   logic          lsu_req_valid, lsu_req_ready, lsu_rsp_valid;
   logic [31:0]   next_pc, pc, inst;
   logic          commit, halted, bus_err;
   logic [CW-1:0] retired;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ysyx_25030093_mc_ctrl #(.XLEN(32), .RESET_PC(RPC), .CNT_W(CW), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst),
      .is_mem(is_mem), .ebreak(ebreak),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
      .next_pc(next_pc), .pc(pc), .inst(inst), .commit(commit), .retired(retired),
      .halted(halted), .bus_err(bus_err)
   );

   typedef struct {
      logic [31:0] ins;
      int          acc;
      int          rsp;
      bit          mem;
      int          lreq;
      int          lrsp;
      bit          eb;
      logic [31:0] npc;
      int          exp_lat;
      logic [31:0] exp_pc;
      int          exp_ret;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Two commits in consecutive cycles are never legal.
   logic prev_commit = 1'b0;
   always @(negedge clk) begin
      if (rst === 1'b1 && commit === 1'b1) begin
         checks++;
         if (prev_commit) begin
            errors++;
            $display("FAIL commit_back_to_back: got 1 expected 0");
         end
      end
      prev_commit <= commit;
   end

   // Plays the IFU/LSU side for one instruction; entered and left at a negedge.
   task automatic run_instr(input vec_t v, input logic [31:0] cur_pc, output int lat, output int ncom);
      int  ph, cnt;
      bit  done;
      ph = 0; cnt = 0; lat = -1; ncom = 0; done = 0;
      is_mem = v.mem; ebreak = v.eb; next_pc = v.npc; ifu_rsp_inst = v.ins;
      for (int c = 0; c < 300 && !done; c++) begin
         ifu_req_ready = 0; ifu_rsp_valid = 0; lsu_req_ready = 0; lsu_rsp_valid = 0;
         if (commit) begin ncom++; lat = c; end
         case (ph)
            0: begin
               if (cnt == 0) chk("fetch_addr", ifu_req_addr, cur_pc);
               chk("fetch_valid_held", ifu_req_valid, 1);
               if (cnt == v.acc) begin ifu_req_ready = 1; ph = 1; cnt = 0; end
               else cnt++;
            end
            1: begin
               cnt++;
               if (cnt == v.rsp) begin ifu_rsp_valid = 1; ph = 2; end
            end
            2: begin
               chk("inst_latched", inst, v.ins);
               if (v.eb) ph = 6;
               else if (v.mem) begin ph = 3; cnt = 0; end
               else ph = 5;
            end
            3: begin
               chk("lsu_valid_held", lsu_req_valid, 1);
               if (cnt == v.lreq) begin lsu_req_ready = 1; ph = 4; cnt = 0; end
               else cnt++;
            end
            4: begin
               cnt++;
               if (cnt == v.lrsp) begin lsu_rsp_valid = 1; ph = 5; end
            end
            default: ph = 6;
         endcase
         @(negedge clk);
         if (ph == 6) done = 1;
      end
      ifu_req_ready = 0; ifu_rsp_valid = 0; lsu_req_ready = 0; lsu_rsp_valid = 0;
      if (!done) chk("instr_timeout", 1, 0);
   endtask

   task automatic do_reset();
      rst = 0;
      ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_inst = '0;
      is_mem = 0; ebreak = 0; lsu_req_ready = 0; lsu_rsp_valid = 0; next_pc = '0;
      repeat (2) @(negedge clk);
      rst = 1;
      @(negedge clk);
   endtask

   vec_t        tbl [5];
   vec_t        v;
   logic [31:0] m_pc;
   int          m_ret;
   int          lat, ncom, bad, n;

   initial begin
      tbl[0] = '{32'h0010_0093, 0, 1, 0, 0, 0, 0, 32'h8000_0004, 3, 32'h8000_0004, 1};
      tbl[1] = '{32'h0020_0113, 5, 2, 0, 0, 0, 0, 32'h8000_0008, 9, 32'h8000_0008, 2};
      tbl[2] = '{32'h0000_2183, 0, 1, 1, 1, 3, 0, 32'h8000_000c, 8, 32'h8000_000c, 3};
      tbl[3] = '{32'h0031_2023, 2, 3, 1, 0, 1, 0, 32'h8000_0100, 9, 32'h8000_0100, 4};
      tbl[4] = '{32'hf01f_f06f, 1, 1, 0, 0, 0, 0, 32'h8000_0000, 4, 32'h8000_0000, 5};

      rst = 0;
      ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_inst = '0;
      is_mem = 0; ebreak = 0; lsu_req_ready = 0; lsu_rsp_valid = 0; next_pc = '0;
      repeat (3) @(negedge clk);
      chk("rst_pc", pc, RPC);
      chk("rst_inst", inst, 0);
      chk("rst_retired", retired, 0);
      chk("rst_commit", commit, 0);
      chk("rst_halted", halted, 0);
      chk("rst_bus_err", bus_err, 0);
      chk("rst_ifu_valid", ifu_req_valid, 0);
      chk("rst_lsu_valid", lsu_req_valid, 0);
      rst = 1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         run_instr(tbl[i], (i == 0) ? RPC : tbl[i-1].exp_pc, lat, ncom);
         chk("tbl_latency", lat, tbl[i].exp_lat);
         chk("tbl_commit_count", ncom, 1);
         chk("tbl_pc", pc, tbl[i].exp_pc);
         chk("tbl_retired", retired, tbl[i].exp_ret);
      end
      m_pc = 32'h8000_0000; m_ret = 5;

      // Ready and response in the same request cycle must not skip the response wait.
      is_mem = 0; ebreak = 0; next_pc = m_pc + 4;
      ifu_req_ready = 1; ifu_rsp_valid = 1; ifu_rsp_inst = 32'hdead_0013;
      @(negedge clk);
      ifu_req_ready = 0; ifu_rsp_valid = 0;
      chk("same_cycle_valid_drop", ifu_req_valid, 0);
      chk("same_cycle_no_commit", commit, 0);
      @(negedge clk);
      ifu_rsp_valid = 1; ifu_rsp_inst = 32'h0020_0113;
      @(negedge clk);
      ifu_rsp_valid = 0;
      chk("same_cycle_inst", inst, 32'h0020_0113);
      chk("same_cycle_exec_no_commit", commit, 0);
      @(negedge clk);
      chk("same_cycle_wb_commit", commit, 1);
      @(negedge clk);
      m_pc = m_pc + 4; m_ret = (m_ret + 1) % (1 << CW);
      chk("same_cycle_pc", pc, m_pc);
      chk("same_cycle_retired", retired, m_ret);

      for (int i = 0; i < 40; i++) begin
         v.ins  = $urandom;
         v.acc  = $urandom_range(0, 3);
         v.rsp  = $urandom_range(1, 3);
         v.mem  = $urandom_range(0, 1);
         v.lreq = $urandom_range(0, 3);
         v.lrsp = $urandom_range(1, 3);
         v.eb   = 0;
         v.npc  = 32'($urandom) & ~32'h3;
         v.exp_lat = v.acc + v.rsp + 2 + (v.mem ? (v.lreq + 1 + v.lrsp) : 0);
         run_instr(v, m_pc, lat, ncom);
         m_pc = v.npc; m_ret = (m_ret + 1) % (1 << CW);
         chk("rnd_latency", lat, v.exp_lat);
         chk("rnd_commit_count", ncom, 1);
         chk("rnd_pc", pc, m_pc);
         chk("rnd_retired", retired, m_ret);
      end

      // Reset while waiting for the LSU response drops the instruction.
      next_pc = 32'h1234_5678; is_mem = 1; ebreak = 0;
      ifu_req_ready = 1;
      @(negedge clk);
      ifu_req_ready = 0; ifu_rsp_valid = 1;
      @(negedge clk);
      ifu_rsp_valid = 0;
      @(negedge clk);
      chk("memrst_lsu_valid", lsu_req_valid, 1);
      lsu_req_ready = 1;
      @(negedge clk);
      lsu_req_ready = 0;
      #2 rst = 0; lsu_rsp_valid = 1;
      #1;
      chk("memrst_pc", pc, RPC);
      chk("memrst_retired", retired, 0);
      chk("memrst_commit", commit, 0);
      chk("memrst_lsu_valid_low", lsu_req_valid, 0);
      bad = 0;
      repeat (2) begin
         @(negedge clk);
         if (commit !== 1'b0 || retired !== '0) bad++;
      end
      chk("memrst_quiet", bad, 0);
      lsu_rsp_valid = 0; is_mem = 0;
      rst = 1;
      @(negedge clk);
      m_pc = RPC; m_ret = 0;

      v = '{32'h0010_0073, 0, 1, 0, 0, 0, 1, 32'hffff_fff0, 2, RPC, 1};
      run_instr(v, m_pc, lat, ncom);
      chk("ebreak_latency", lat, v.exp_lat);
      chk("ebreak_commit_count", ncom, 1);
      chk("ebreak_halted", halted, 1);
      chk("ebreak_pc", pc, v.exp_pc);
      chk("ebreak_retired", retired, v.exp_ret);
      ebreak = 0;
      bad = 0;
      repeat (20) begin
         ifu_req_ready = 1; ifu_rsp_valid = 1; lsu_rsp_valid = 1;
         @(negedge clk);
         if (ifu_req_valid !== 1'b0 || commit !== 1'b0 || halted !== 1'b1) bad++;
      end
      chk("halt_quiet", bad, 0);

      do_reset();
`ifdef YSYX_25030093_BUS_TIMEOUT_EN
      ifu_req_ready = 1;
      @(negedge clk);
      ifu_req_ready = 0;
      n = 0;
      while (halted !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("timeout_wait_cycles", n, 8);
      chk("timeout_bus_err", bus_err, 1);
      chk("timeout_retired", retired, 0);
`else
      bad = 0;
      n = 0;
      repeat (30) begin
         @(negedge clk);
         n++;
         if (bus_err !== 1'b0 || halted !== 1'b0 || ifu_req_valid !== 1'b1) bad++;
      end
      chk("no_timeout_wait", bad, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ysyx_25030093_mc_ctrl.md
YSYX_25030093_MC_CTRL -- requirements
Module: ysyx_25030093_mc_ctrl

Interface
REQ-001 Parameter XLEN, default 32, address/PC width.
REQ-002 Parameter RESET_PC, default 32'h8000_0000, PC value loaded at reset.
REQ-003 Parameter CNT_W, default 64, retired-instruction counter width.
REQ-004 Parameter TIMEOUT, default 255, max wait cycles per bus transaction (used only when BUS_TIMEOUT_EN defined).
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 ifu_req_valid  out  1  fetch request valid.
REQ-008 ifu_req_ready  in  1  fetch request accepted.
REQ-009 ifu_req_addr  out  XLEN  fetch address (equals pc).
REQ-010 ifu_rsp_valid  in  1  fetch data valid.
REQ-011 ifu_rsp_inst  in  32  fetched instruction.
REQ-012 is_mem  in  1  decoded instruction is load/store (sampled in EXEC).
REQ-013 ebreak  in  1  decoded instruction is ebreak (sampled in EXEC).
REQ-014 lsu_req_valid  out  1  LSU request valid.
REQ-015 lsu_req_ready  in  1  LSU request accepted.
REQ-016 lsu_rsp_valid  in  1  LSU completion.
REQ-017 next_pc  in  XLEN  PC computed by datapath for current instruction.
REQ-018 pc  out  XLEN  current PC.
REQ-019 inst  out  32  latched instruction, stable from EXEC until next fetch response.
REQ-020 commit  out  1  one-cycle pulse gating GPR/CSR write enables.
REQ-021 retired  out  CNT_W  count of committed instructions.
REQ-022 halted  out  1  core stopped.
REQ-023 bus_err  out  1  sticky timeout flag (tied 0 without BUS_TIMEOUT_EN).

Function
REQ-024 States SHALL be FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT; one-hot or binary encoding free.
REQ-025 FETCH_REQ: ifu_req_valid=1; on ifu_req_ready -> FETCH_WAIT; valid SHALL stay high and addr stable until accepted.
REQ-026 FETCH_WAIT: on ifu_rsp_valid latch ifu_rsp_inst into inst -> EXEC; ifu_req_ready and ifu_rsp_valid in same FETCH_REQ cycle SHALL NOT skip FETCH_WAIT (response expected one or more cycles after accept).
REQ-027 EXEC (exactly one cycle): ebreak=1 -> HALT with commit pulse; else is_mem=1 -> MEM_REQ; else -> WB.
REQ-028 MEM_REQ: lsu_req_valid=1 until lsu_req_ready, then -> MEM_WAIT; MEM_WAIT on lsu_rsp_valid -> WB.
REQ-029 WB (one cycle): commit=1, pc<=next_pc, retired+=1, -> FETCH_REQ.
REQ-030 ebreak commit SHALL increment retired but SHALL NOT update pc.
REQ-031 retired SHALL wrap modulo 2^CNT_W without flag.
REQ-032 HALT: halted=1, all valid/commit outputs 0, exits only by reset.
REQ-033 Minimum latency non-memory instruction: 4 cycles (FETCH_REQ, FETCH_WAIT, EXEC, WB) with zero-wait bus.
REQ-034 commit SHALL be high only in WB or EXEC-with-ebreak, never two consecutive cycles.

Reset
REQ-035 rst low SHALL immediately force state FETCH_REQ-pending, pc=RESET_PC, inst=0, retired=0, commit=0, halted=0, bus_err=0, all valid outputs 0.
REQ-036 First fetch request SHALL issue on the first rising edge after rst deasserts; reset mid-transaction SHALL drop it with no commit.

Configuration
REQ-037 Macro YSYX_25030093_BUS_TIMEOUT_EN: when defined, a wait counter counts cycles in FETCH_REQ/FETCH_WAIT/MEM_REQ/MEM_WAIT, clears on each state change; reaching TIMEOUT SHALL set bus_err and enter HALT without commit.
REQ-038 Without the macro no counter exists, waits are unbounded, bus_err=0.

Verification
REQ-039 Reset release, zero-wait IFU, inst=addi, next_pc=pc+4 -> commit at cycle 4, pc=0x8000_0004, retired=1.
REQ-040 ifu_req_ready held low 5 cycles -> ifu_req_valid high and ifu_req_addr constant all 5 cycles, no commit.
REQ-041 is_mem=1, lsu_rsp_valid after 3 cycles -> commit exactly once, 1 cycle after lsu_rsp_valid.
REQ-042 ebreak=1 in EXEC -> one commit, halted=1, pc unchanged, no further ifu_req_valid for 20 cycles.
REQ-043 rst low during MEM_WAIT -> pc=0x8000_0000, retired=0, no commit pulse.
REQ-044 BUS_TIMEOUT_EN, TIMEOUT=8, ifu_rsp_valid never asserted -> bus_err=1 and halted=1 after 8 wait cycles, retired unchanged.
